// File: rtl/sna_axi_lite_master.sv
// AXI4-Lite master for the SNA bridge: runs one decoded request as a single
// AXI read or write and returns the response tagged with its POV address.
module sna_axi_lite_master (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic        req_read,
  input  logic [3:0]  req_pov_addr,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [2:0]  m_awprot,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [2:0]  m_arprot,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_resp,
  output logic        rsp_read,
  output logic [3:0]  rsp_pov_addr,
  output logic [15:0] txn_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic [3:0]  pov_q, pov_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        rsp_read_q, rsp_read_d;
  logic [15:0] txn_count_q, txn_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      pov_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      rsp_read_q  <= 1'b0;
      txn_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
      pov_q       <= pov_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_read_q  <= rsp_read_d;
      txn_count_q <= txn_count_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_d      = read_q;
    pov_d       = pov_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_read_d  = rsp_read_q;
    txn_count_d = txn_count_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          wdata_d   = req_data;
          read_d    = req_read;
          pov_d     = req_pov_addr;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_read ? S_RD_ADDR : S_WR;
        end
      end
      S_WR: begin
        // AW and W retire independently; both may land in the same cycle.
        if (m_awready) aw_done_d = 1'b1;
        if (m_wready)  w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          rsp_resp_d = m_bresp;
          rsp_data_d = '0;
          rsp_read_d = 1'b0;
          state_d    = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (m_arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (m_rvalid) begin
          rsp_resp_d = m_rresp;
          rsp_data_d = m_rdata;
          rsp_read_d = 1'b1;
          state_d    = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          txn_count_d = txn_count_q + 16'd1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every output is a register or a pure decode of state and done flags.
  assign req_ready    = (state_q == S_IDLE);
  assign m_awaddr     = addr_q;
  assign m_awvalid    = (state_q == S_WR) && !aw_done_q;
  assign m_awprot     = 3'b000;
  assign m_wdata      = wdata_q;
  assign m_wstrb      = 4'hF;
  assign m_wvalid     = (state_q == S_WR) && !w_done_q;
  assign m_bready     = (state_q == S_WR_RESP);
  assign m_araddr     = addr_q;
  assign m_arvalid    = (state_q == S_RD_ADDR);
  assign m_arprot     = 3'b000;
  assign m_rready     = (state_q == S_RD_DATA);
  assign rsp_valid    = (state_q == S_RSP);
  assign rsp_data     = rsp_data_q;
  assign rsp_resp     = rsp_resp_q;
  assign rsp_read     = rsp_read_q;
  assign rsp_pov_addr = pov_q;
  assign txn_count    = txn_count_q;

  logic unused_read;
  assign unused_read = read_q;

endmodule

// File: tb/tb_sna_axi_lite_master.sv
// Scoreboard bench for sna_axi_lite_master: directed scenarios plus randomized
// transactions against a transaction-level model of the expected responses.
module tb_sna_axi_lite_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_read;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_pov_addr;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic        rsp_valid, rsp_ready, rsp_read;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_pov_addr;
  logic [15:0] txn_count;

  sna_axi_lite_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_read(req_read), .req_pov_addr(req_pov_addr),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .rsp_read(rsp_read), .rsp_pov_addr(rsp_pov_addr),
    .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        read;
    logic [3:0]  pov;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] cnt_model = 16'd0;
  int          rsp_hold = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Response sink: holds rsp_ready low for rsp_hold cycles of each response.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid && rsp_hold > 0) begin
        rsp_ready = 1'b0;
        rsp_hold--;
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      check("txn_count", txn_count, cnt_model);
      if (rsp_valid) begin
        check("req_ready_in_rsp", req_ready, 1'b0);
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 1'b1, 1'b0);
        end else begin
          e = exp_q[0];
          check("rsp_data", rsp_data, e.data);
          check("rsp_resp", rsp_resp, e.resp);
          check("rsp_read", rsp_read, e.read);
          check("rsp_pov", rsp_pov_addr, e.pov);
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            cnt_model = cnt_model + 16'd1;
          end
        end
      end
    end
  end

  task automatic send_req(input logic rd, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] pov, output bit ok);
    int n = 0;
    bit hs;
    req_valid = 1'b1; req_read = rd; req_addr = addr; req_data = data; req_pov_addr = pov;
    do begin
      hs = req_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 200);
    req_valid = 1'b0;
    req_addr = $urandom; req_data = $urandom; req_read = ~rd; req_pov_addr = ~pov;
    ok = hs;
    check("req_handshake", hs, 1'b1);
  endtask

  // One complete transaction: request, AXI slave behaviour, latency checks.
  task automatic run_txn(input logic rd, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] pov, input int a_dly, input int w_dly,
                         input int r_dly, input logic [31:0] rdata, input logic [1:0] resp,
                         input int hold);
    exp_t e;
    bit ok, aw_ok, w_ok, aw_hs, w_hs;
    int n;
    e.data = rd ? rdata : 32'h0;
    e.resp = resp;
    e.read = rd;
    e.pov  = pov;
    exp_q.push_back(e);
    send_req(rd, addr, data, pov, ok);
    if (!ok) return;
    if (!rd) begin
      aw_ok = 0; w_ok = 0; n = 0;
      while (!(aw_ok && w_ok) && n < 100) begin
        check("awvalid", m_awvalid, !aw_ok);
        check("wvalid", m_wvalid, !w_ok);
        check("bready_early", m_bready, 1'b0);
        if (!aw_ok) check("awaddr", m_awaddr, addr);
        if (!w_ok) begin
          check("wdata", m_wdata, data);
          check("wstrb", m_wstrb, 4'hF);
        end
        m_awready = !aw_ok && (n >= a_dly);
        m_wready  = !w_ok && (n >= w_dly);
        aw_hs = m_awvalid && m_awready;
        w_hs  = m_wvalid && m_wready;
        @(posedge clk); #1;
        n++;
        m_awready = 1'b0; m_wready = 1'b0;
        if (aw_hs) aw_ok = 1;
        if (w_hs)  w_ok  = 1;
      end
      check("aw_w_complete", aw_ok && w_ok, 1'b1);
      for (int i = 0; i < r_dly; i++) begin
        check("bready", m_bready, 1'b1);
        @(posedge clk); #1;
      end
      check("bready", m_bready, 1'b1);
      check("awvalid_after", m_awvalid | m_wvalid, 1'b0);
      rsp_hold = hold;
      m_bvalid = 1'b1; m_bresp = resp;
      @(posedge clk); #1;
      m_bvalid = 1'b0; m_bresp = 2'($urandom);
    end else begin
      for (int i = 0; i < a_dly; i++) begin
        check("arvalid_hold", m_arvalid, 1'b1);
        check("araddr", m_araddr, addr);
        @(posedge clk); #1;
      end
      check("arvalid", m_arvalid, 1'b1);
      check("araddr", m_araddr, addr);
      check("arprot", m_arprot, 3'b000);
      m_arready = 1'b1;
      @(posedge clk); #1;
      m_arready = 1'b0;
      for (int i = 0; i < r_dly; i++) begin
        check("rready", m_rready, 1'b1);
        check("arvalid_drop", m_arvalid, 1'b0);
        @(posedge clk); #1;
      end
      check("rready", m_rready, 1'b1);
      rsp_hold = hold;
      m_rvalid = 1'b1; m_rdata = rdata; m_rresp = resp;
      @(posedge clk); #1;
      m_rvalid = 1'b0; m_rdata = $urandom; m_rresp = 2'($urandom);
    end
    check("rsp_valid_latency", rsp_valid, 1'b1);
    if (hold == 0) begin
      @(posedge clk); #1;
      check("next_req_ready", req_ready, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic rd;
    logic [31:0] a, d, rdat;
    logic [3:0] pv;
    logic [1:0] rs;
    int ad, wd, rdl, hd;

    rst_n = 1'b1;
    req_valid = 0; req_addr = 0; req_data = 0; req_read = 0; req_pov_addr = 0;
    m_awready = 0; m_wready = 0; m_bresp = 0; m_bvalid = 0;
    m_arready = 0; m_rdata = 0; m_rresp = 0; m_rvalid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 6'b0);
    check("rst_rsp_data", rsp_data, 32'h0);
    check("rst_rsp_fields", {rsp_resp, rsp_read, rsp_pov_addr}, 7'b0);
    check("rst_txn_count", txn_count, 16'h0);
    check("prot", {m_awprot, m_arprot}, 6'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write.
    run_txn(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'h5, 0, 0, 0, 32'h0, 2'b00, 0);
    check("count_after_first", txn_count, 16'd1);
    // Read with address and data wait states.
    run_txn(1'b1, 32'h0000_2004, 32'h0, 4'hA, 3, 0, 3, 32'h1234_5678, 2'b00, 0);
    // W completes 4 cycles after AW.
    run_txn(1'b0, 32'h0000_3008, 32'hCAFE_F00D, 4'h3, 0, 4, 1, 32'h0, 2'b00, 0);
    // AW completes after W.
    run_txn(1'b0, 32'h0000_300C, 32'h0BAD_F00D, 4'h7, 3, 0, 0, 32'h0, 2'b01, 0);
    // SLVERR with rsp backpressure, then DECERR read.
    run_txn(1'b0, 32'h0000_4000, 32'h5555_AAAA, 4'hC, 0, 0, 0, 32'h0, 2'b10, 5);
    run_txn(1'b1, 32'h0000_4004, 32'h0, 4'hF, 0, 0, 0, 32'h8765_4321, 2'b11, 2);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      a = $urandom & 32'hFFFF_FFFC;
      d = $urandom;
      pv = 4'($urandom);
      rdat = $urandom;
      rs = 2'($urandom);
      ad = int'($urandom_range(0, 3));
      wd = int'($urandom_range(0, 3));
      rdl = int'($urandom_range(0, 3));
      hd = int'($urandom_range(0, 3));
      run_txn(rd, a, d, pv, ad, wd, rdl, rdat, rs, hd);
    end
    repeat (8) @(posedge clk);
    #1;

    // Reset while a read waits for its data.
    send_req(1'b1, 32'h0000_5000, 32'h0, 4'h9, ok);
    check("mid_arvalid", m_arvalid, 1'b1);
    m_arready = 1'b1;
    @(posedge clk); #1;
    m_arready = 1'b0;
    check("mid_rready", m_rready, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid}, 6'b0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_count", txn_count, 16'h0);
    check("mid_rst_rsp_data", rsp_data, 32'h0);
    exp_q.delete();
    cnt_model = 16'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 32'h0000_6000, 32'h0123_4567, 4'h2, 0, 0, 0, 32'h0, 2'b00, 0);
    check("count_after_reset", txn_count, 16'd1);

    // Counter wrap: preload near the top of the range.
    force dut.txn_count_q = 16'hFFFE;
    cnt_model = 16'hFFFE;
    @(posedge clk); #1;
    release dut.txn_count_q;
    @(posedge clk); #1;
    run_txn(1'b1, 32'h0000_7000, 32'h0, 4'h1, 0, 0, 0, 32'hA5A5_5A5A, 2'b00, 0);
    check("count_ffff", txn_count, 16'hFFFF);
    run_txn(1'b0, 32'h0000_7004, 32'h1111_2222, 4'h4, 0, 0, 0, 32'h0, 2'b00, 0);
    check("count_wrap", txn_count, 16'h0000);
    run_txn(1'b0, 32'h0000_7008, 32'h3333_4444, 4'h8, 1, 2, 1, 32'h0, 2'b10, 1);

    repeat (10) @(posedge clk);
    #1;
    check("scoreboard_drain", exp_q.size(), 32'd0);
    check("final_count", txn_count, cnt_model);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
